// File: rtl/fsb_adapter_pkg.sv
// Shared FSB packet definitions for the host-side adapter and its request buffer.
package fsb_adapter_pkg;

    localparam int FSB_PKT_WIDTH     = 80;
    localparam int FSB_RESP_FLAG_BIT = 79;
    localparam int OUTSTANDING_WIDTH = 8;

    typedef logic [FSB_PKT_WIDTH-1:0] fsb_pkt_t;

endpackage

// File: rtl/fsb_pkt_fifo.sv
// Valid/ready FIFO of FSB packets; head is read straight from the storage flops
// so a packet written on one edge is presented the following cycle.
module fsb_pkt_fifo
    import fsb_adapter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_v_i,
    input  fsb_pkt_t               push_data_i,
    output logic                   push_r_o,
    output logic                   pop_v_o,
    output fsb_pkt_t               pop_data_o,
    input  logic                   pop_r_i,
    output logic [$clog2(DEPTH):0] occupancy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fsb_pkt_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_push_rdy;

    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_next;

    assign w_push = push_v_i & r_push_rdy;
    assign w_pop  = (r_count != '0) & pop_r_i;

    // NOTE: always_comb assigns every output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_push_rdy <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_count_next;
            r_push_rdy <= (w_count_next != CW'(DEPTH));
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data_i;
    end

    assign push_r_o    = r_push_rdy;
    assign pop_v_o     = (r_count != '0);
    assign pop_data_o  = r_mem[r_rd_ptr];
    assign occupancy_o = r_count;

endmodule

// File: rtl/fsb_host_req_buffer.sv
// Host-to-FSB request buffer with outstanding-response credit gating, a 2-entry
// response skid buffer and host-visible occupancy/credit/traffic status.
module fsb_host_req_buffer
    import fsb_adapter_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         req_v_i,
    input  fsb_pkt_t                     req_data_i,
    output logic                         req_r_o,
    output logic                         fsb_v_o,
    output fsb_pkt_t                     fsb_data_o,
    input  logic                         fsb_r_i,
    input  logic                         fsb_resp_v_i,
    input  fsb_pkt_t                     fsb_resp_data_i,
    output logic                         fsb_resp_r_o,
    output logic                         resp_v_o,
    output fsb_pkt_t                     resp_data_o,
    input  logic                         resp_r_i,
    output logic [$clog2(DEPTH):0]       occupancy_o,
    output logic [OUTSTANDING_WIDTH-1:0] outstanding_o,
    output logic [CNT_WIDTH-1:0]         tx_count_o,
    output logic [CNT_WIDTH-1:0]         rx_count_o,
    output logic                         resp_underflow_o
);

    logic                         w_fifo_v;
    fsb_pkt_t                     w_fifo_data;
    logic                         w_gate;
    logic                         w_fsb_v;
    logic                         w_issue;
    logic                         w_inc;
    logic                         w_resp_in;
    logic                         w_resp_out;
    logic [1:0]                   w_skid_cnt_next;

    logic [OUTSTANDING_WIDTH-1:0] r_outstanding;
    logic                         r_underflow;
    logic [CNT_WIDTH-1:0]         r_tx_count;
    logic [CNT_WIDTH-1:0]         r_rx_count;
    fsb_pkt_t                     r_skid [2];
    logic                         r_skid_wr;
    logic                         r_skid_rd;
    logic [1:0]                   r_skid_cnt;
    logic                         r_resp_rdy;

    fsb_pkt_fifo #(.DEPTH(DEPTH)) u_req_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_v_i    (req_v_i),
        .push_data_i (req_data_i),
        .push_r_o    (req_r_o),
        .pop_v_o     (w_fifo_v),
        .pop_data_o  (w_fifo_data),
        .pop_r_i     (fsb_r_i & ~w_gate),
        .occupancy_o (occupancy_o)
    );

    // A response-expecting head waits for a free credit; nothing behind it may pass.
    assign w_gate    = w_fifo_data[FSB_RESP_FLAG_BIT] &&
                       (r_outstanding == OUTSTANDING_WIDTH'(MAX_OUTSTANDING));
    assign w_fsb_v   = w_fifo_v & ~w_gate;
    assign w_issue   = w_fsb_v & fsb_r_i;
    assign w_inc     = w_issue & w_fifo_data[FSB_RESP_FLAG_BIT];
    assign w_resp_in = fsb_resp_v_i & r_resp_rdy;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_outstanding <= '0;
            r_underflow   <= 1'b0;
            r_tx_count    <= '0;
            r_rx_count    <= '0;
        end else begin
            if (w_resp_in && (r_outstanding == '0)) r_underflow <= 1'b1;
            if (w_inc && !w_resp_in)
                r_outstanding <= r_outstanding + OUTSTANDING_WIDTH'(1);
            else if (!w_inc && w_resp_in && (r_outstanding != '0))
                r_outstanding <= r_outstanding - OUTSTANDING_WIDTH'(1);
            if (w_issue)   r_tx_count <= r_tx_count + CNT_WIDTH'(1);
            if (w_resp_in) r_rx_count <= r_rx_count + CNT_WIDTH'(1);
        end
    end

    assign w_resp_out = (r_skid_cnt != 2'd0) & resp_r_i;

    always_comb begin
        w_skid_cnt_next = r_skid_cnt;
        case ({w_resp_in, w_resp_out})
            2'b10:   w_skid_cnt_next = r_skid_cnt + 2'd1;
            2'b01:   w_skid_cnt_next = r_skid_cnt - 2'd1;
            default: w_skid_cnt_next = r_skid_cnt;
        endcase
    end

    // Ready is registered from the next entry count, so it never admits a third entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_skid_wr  <= 1'b0;
            r_skid_rd  <= 1'b0;
            r_skid_cnt <= 2'd0;
            r_resp_rdy <= 1'b0;
        end else begin
            if (w_resp_in)  r_skid_wr <= ~r_skid_wr;
            if (w_resp_out) r_skid_rd <= ~r_skid_rd;
            r_skid_cnt <= w_skid_cnt_next;
            r_resp_rdy <= (w_skid_cnt_next != 2'd2);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_resp_in) r_skid[r_skid_wr] <= fsb_resp_data_i;
    end

    assign fsb_v_o          = w_fsb_v;
    assign fsb_data_o       = w_fifo_data;
    assign fsb_resp_r_o     = r_resp_rdy;
    assign resp_v_o         = (r_skid_cnt != 2'd0);
    assign resp_data_o      = r_skid[r_skid_rd];
    assign outstanding_o    = r_outstanding;
    assign tx_count_o       = r_tx_count;
    assign rx_count_o       = r_rx_count;
    assign resp_underflow_o = r_underflow;

endmodule

// File: tb/tb_fsb_host_req_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model of the request buffer.
module tb_fsb_host_req_buffer;
    import fsb_adapter_pkg::*;

    localparam int DEPTH   = 16;
    localparam int MAX_OUT = 8;
    localparam int CNT_W   = 8;
    localparam int OCC_W   = $clog2(DEPTH) + 1;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         req_v_i;
    fsb_pkt_t     req_data_i;
    logic         req_r_o;
    logic         fsb_v_o;
    fsb_pkt_t     fsb_data_o;
    logic         fsb_r_i;
    logic         fsb_resp_v_i;
    fsb_pkt_t     fsb_resp_data_i;
    logic         fsb_resp_r_o;
    logic         resp_v_o;
    fsb_pkt_t     resp_data_o;
    logic         resp_r_i;
    logic [OCC_W-1:0] occupancy_o;
    logic [7:0]       outstanding_o;
    logic [CNT_W-1:0] tx_count_o;
    logic [CNT_W-1:0] rx_count_o;
    logic             resp_underflow_o;

    fsb_host_req_buffer #(
        .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_data_i(req_data_i), .req_r_o(req_r_o),
        .fsb_v_o(fsb_v_o), .fsb_data_o(fsb_data_o), .fsb_r_i(fsb_r_i),
        .fsb_resp_v_i(fsb_resp_v_i), .fsb_resp_data_i(fsb_resp_data_i),
        .fsb_resp_r_o(fsb_resp_r_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_r_i(resp_r_i),
        .occupancy_o(occupancy_o), .outstanding_o(outstanding_o),
        .tx_count_o(tx_count_o), .rx_count_o(rx_count_o),
        .resp_underflow_o(resp_underflow_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    fsb_pkt_t         req_q[$];
    fsb_pkt_t         resp_q[$];
    int               m_out = 0;
    bit               m_uf = 1'b0;
    logic [CNT_W-1:0] m_tx = '0;
    logic [CNT_W-1:0] m_rx = '0;
    bit               m_in_reset = 1'b1;
    bit               m_valid = 1'b0;
    bit               hs_push, hs_issue, hs_rin, hs_rout;
    fsb_pkt_t         last_resp;

    function automatic fsb_pkt_t rand_pkt(input bit flag);
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        t[FSB_RESP_FLAG_BIT] = flag;
        return t[79:0];
    endfunction

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic cycle();
        bit e_req_r, e_fsb_v, e_resp_r, e_resp_v;
        int inc;
        fsb_pkt_t h;
        #1;
        e_req_r  = !m_in_reset && (req_q.size() < DEPTH);
        e_resp_r = !m_in_reset && (resp_q.size() < 2);
        e_fsb_v  = (req_q.size() > 0) && !(req_q[0][FSB_RESP_FLAG_BIT] && m_out == MAX_OUT);
        e_resp_v = (resp_q.size() > 0);
        if (m_valid) begin
            check("req_r",       80'(req_r_o),          80'(e_req_r));
            check("fsb_v",       80'(fsb_v_o),          80'(e_fsb_v));
            if (e_fsb_v) check("fsb_data", fsb_data_o, req_q[0]);
            check("fsb_resp_r",  80'(fsb_resp_r_o),     80'(e_resp_r));
            check("resp_v",      80'(resp_v_o),         80'(e_resp_v));
            if (e_resp_v) check("resp_data", resp_data_o, resp_q[0]);
            check("occupancy",   80'(occupancy_o),      80'(req_q.size()));
            check("outstanding", 80'(outstanding_o),    80'(m_out));
            check("tx_count",    80'(tx_count_o),       80'(m_tx));
            check("rx_count",    80'(rx_count_o),       80'(m_rx));
            check("underflow",   80'(resp_underflow_o), 80'(m_uf));
        end
        hs_push  = req_v_i && e_req_r;
        hs_issue = e_fsb_v && fsb_r_i;
        hs_rin   = fsb_resp_v_i && e_resp_r;
        hs_rout  = e_resp_v && resp_r_i;
        @(posedge clk_i);
        if (reset_i) begin
            req_q.delete();
            resp_q.delete();
            m_out = 0; m_uf = 1'b0; m_tx = '0; m_rx = '0;
            m_in_reset = 1'b1; m_valid = 1'b1;
            hs_push = 1'b0; hs_issue = 1'b0; hs_rin = 1'b0; hs_rout = 1'b0;
        end else begin
            m_in_reset = 1'b0;
            inc = 0;
            if (hs_issue) begin
                h = req_q.pop_front();
                m_tx++;
                inc = int'(h[FSB_RESP_FLAG_BIT]);
            end
            if (hs_rin && m_out == 0) m_uf = 1'b1;
            m_out = m_out + inc - int'(hs_rin);
            if (m_out < 0) m_out = 0;
            if (hs_push) req_q.push_back(req_data_i);
            if (hs_rout) void'(resp_q.pop_front());
            if (hs_rin) begin
                resp_q.push_back(fsb_resp_data_i);
                m_rx++;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset(input int n);
        reset_i = 1'b1; req_v_i = 1'b0; fsb_resp_v_i = 1'b0; fsb_r_i = 1'b0; resp_r_i = 1'b1;
        repeat (n) cycle();
        check("rst_occ",       80'(occupancy_o),      80'(0));
        check("rst_out",       80'(outstanding_o),    80'(0));
        check("rst_tx",        80'(tx_count_o),       80'(0));
        check("rst_rx",        80'(rx_count_o),       80'(0));
        check("rst_fsb_v",     80'(fsb_v_o),          80'(0));
        check("rst_resp_v",    80'(resp_v_o),         80'(0));
        check("rst_req_r",     80'(req_r_o),          80'(0));
        check("rst_resp_r",    80'(fsb_resp_r_o),     80'(0));
        check("rst_underflow", 80'(resp_underflow_o), 80'(0));
        reset_i = 1'b0;
        cycle();
        check("req_r_after_rst", 80'(req_r_o), 80'(1));
    endtask

    task automatic push_n(input int n, input bit flag, input bit fr);
        int got = 0;
        int guard = 0;
        fsb_r_i = fr; req_v_i = 1'b1; req_data_i = rand_pkt(flag);
        while (got < n && guard < 200) begin
            cycle();
            guard++;
            if (hs_push) begin
                got++;
                req_data_i = rand_pkt(flag);
            end
        end
        req_v_i = 1'b0;
        check("push_count", 80'(got), 80'(n));
    endtask

    task automatic send_resp(input int n);
        int got = 0;
        int guard = 0;
        fsb_resp_v_i = 1'b1; fsb_resp_data_i = rand_pkt(1'b0); last_resp = fsb_resp_data_i;
        while (got < n && guard < 50) begin
            cycle();
            guard++;
            if (hs_rin) begin
                got++;
                last_resp = fsb_resp_data_i;
                fsb_resp_data_i = rand_pkt(1'b0);
            end
        end
        fsb_resp_v_i = 1'b0;
        check("resp_count", 80'(got), 80'(n));
    endtask

    initial begin
        fsb_pkt_t sent [3];
        int k;
        int resp_pct;
        reset_i = 1'b1; req_v_i = 1'b0; req_data_i = '0; fsb_r_i = 1'b0;
        fsb_resp_v_i = 1'b0; fsb_resp_data_i = '0; resp_r_i = 1'b1;

        // Fill then drain in order
        do_reset(2);
        push_n(DEPTH, 1'b0, 1'b0);
        check("fill_req_r", 80'(req_r_o),     80'(0));
        check("fill_occ",   80'(occupancy_o), 80'(DEPTH));
        fsb_r_i = 1'b1;
        idle(DEPTH);
        fsb_r_i = 1'b0;
        check("drain_tx",  80'(tx_count_o),    80'(DEPTH));
        check("drain_occ", 80'(occupancy_o),   80'(0));
        check("drain_out", 80'(outstanding_o), 80'(0));

        // Credit stall and release
        do_reset(1);
        push_n(10, 1'b1, 1'b1);
        idle(4);
        check("stall_out",   80'(outstanding_o), 80'(MAX_OUT));
        check("stall_tx",    80'(tx_count_o),    80'(MAX_OUT));
        check("stall_occ",   80'(occupancy_o),   80'(2));
        check("stall_fsb_v", 80'(fsb_v_o),       80'(0));
        send_resp(1);
        check("release_fsb_v", 80'(fsb_v_o),       80'(1));
        check("release_out",   80'(outstanding_o), 80'(MAX_OUT - 1));
        cycle();
        check("ninth_tx",    80'(tx_count_o),    80'(MAX_OUT + 1));
        check("ninth_out",   80'(outstanding_o), 80'(MAX_OUT));
        check("ninth_fsb_v", 80'(fsb_v_o),       80'(0));
        fsb_r_i = 1'b0;

        // Same-cycle issue and response
        do_reset(1);
        push_n(3, 1'b1, 1'b1);
        idle(2);
        check("simul_pre_out", 80'(outstanding_o), 80'(3));
        push_n(1, 1'b1, 1'b0);
        fsb_r_i = 1'b1; fsb_resp_v_i = 1'b1; fsb_resp_data_i = rand_pkt(1'b0);
        cycle();
        fsb_r_i = 1'b0; fsb_resp_v_i = 1'b0;
        check("simul_out", 80'(outstanding_o), 80'(3));
        check("simul_tx",  80'(tx_count_o),    80'(4));
        check("simul_rx",  80'(rx_count_o),    80'(1));

        // Response with nothing outstanding
        do_reset(1);
        send_resp(1);
        check("uf_resp_v",    80'(resp_v_o),         80'(1));
        check("uf_resp_data", resp_data_o,           last_resp);
        check("uf_flag",      80'(resp_underflow_o), 80'(1));
        check("uf_out",       80'(outstanding_o),    80'(0));
        idle(3);
        check("uf_sticky",    80'(resp_underflow_o), 80'(1));

        // Response backpressure
        do_reset(1);
        resp_r_i = 1'b0;
        send_resp(1); sent[0] = last_resp;
        send_resp(1); sent[1] = last_resp;
        check("bp_resp_r", 80'(fsb_resp_r_o), 80'(0));
        sent[2] = rand_pkt(1'b0);
        fsb_resp_data_i = sent[2]; fsb_resp_v_i = 1'b1;
        idle(3);
        check("bp_rx_held", 80'(rx_count_o), 80'(2));
        resp_r_i = 1'b1;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (resp_v_o) begin
                if (k < 3) check("bp_order", resp_data_o, sent[k]);
                k++;
            end
            cycle();
            if (hs_rin) fsb_resp_v_i = 1'b0;
        end
        fsb_resp_v_i = 1'b0;
        check("bp_out_count", 80'(k), 80'(3));

        // Reset mid-stream, then a late in-flight response
        do_reset(1);
        push_n(2, 1'b1, 1'b1);
        idle(2);
        push_n(5, 1'b0, 1'b0);
        check("mid_occ_pre", 80'(occupancy_o),   80'(5));
        check("mid_out_pre", 80'(outstanding_o), 80'(2));
        reset_i = 1'b1;
        cycle();
        reset_i = 1'b0;
        check("mid_occ",    80'(occupancy_o),   80'(0));
        check("mid_out",    80'(outstanding_o), 80'(0));
        check("mid_tx",     80'(tx_count_o),    80'(0));
        check("mid_rx",     80'(rx_count_o),    80'(0));
        check("mid_fsb_v",  80'(fsb_v_o),       80'(0));
        check("mid_resp_v", 80'(resp_v_o),      80'(0));
        fsb_r_i = 1'b1;
        idle(2);
        send_resp(1);
        check("late_resp_uf", 80'(resp_underflow_o), 80'(1));

        // Randomized traffic, alternating light and heavy response rates
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            resp_pct = ((i / 500) % 2 == 0) ? 10 : 45;
            if (!req_v_i || hs_push) begin
                req_v_i    = ($urandom_range(0, 99) < 60);
                req_data_i = rand_pkt($urandom_range(0, 99) < 60);
            end
            if (!fsb_resp_v_i || hs_rin) begin
                fsb_resp_v_i    = ($urandom_range(0, 99) < resp_pct);
                fsb_resp_data_i = rand_pkt(1'b0);
            end
            fsb_r_i  = ($urandom_range(0, 99) < 70);
            resp_r_i = ($urandom_range(0, 99) < 75);
            reset_i  = ($urandom_range(0, 999) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsb_host_req_buffer.md
Name: fsb_host_req_buffer

Overview:
Sits directly downstream of the AXI-Lite-to-FSB adapter, between its 80-bit master/slave packet ports and the FSB fabric. Buffers host-to-FSB request packets in a parameterised FIFO. Throttles issue of response-expecting requests against an outstanding-response credit limit. Returns FSB response packets to the adapter through a 2-entry skid buffer, and exposes occupancy, credit and traffic counters for host-visible status.

Parameters:
DEPTH, 16, request FIFO entries; power of two, >= 2
MAX_OUTSTANDING, 8, max in-flight response-expecting requests; 1..255
CNT_WIDTH, 32, width of traffic counters; counters wrap

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
req_v_i  in  1  request valid, from adapter master side
req_data_i  in  80  request packet; bit 79 = response-expected flag
req_r_o  out  1  request ready to adapter
fsb_v_o  out  1  request valid to FSB
fsb_data_o  out  80  request packet to FSB
fsb_r_i  in  1  FSB ready
fsb_resp_v_i  in  1  response valid from FSB
fsb_resp_data_i  in  80  response packet
fsb_resp_r_o  out  1  response ready to FSB
resp_v_o  out  1  response valid to adapter slave side
resp_data_o  out  80  response packet to adapter
resp_r_i  in  1  adapter ready
occupancy_o  out  $clog2(DEPTH)+1  request FIFO entries
outstanding_o  out  8  in-flight response-expecting requests
tx_count_o  out  CNT_WIDTH  requests issued to FSB
rx_count_o  out  CNT_WIDTH  responses accepted from FSB
resp_underflow_o  out  1  sticky: response received with outstanding==0

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on clk_i/reset_i.
- Reset, as of the first edge with reset_i=1:
  - FIFO empty; all counters 0; resp_underflow_o=0.
  - req_r_o=0 while reset_i=1; req_r_o=1 the cycle after reset deasserts.
  - fsb_v_o=0, resp_v_o=0, fsb_resp_r_o=0 during reset.
- Handshakes: a transfer occurs on a rising edge with valid&ready high. A valid, once raised, holds with stable data until accepted. That rule applies to fsb_v_o and resp_v_o.
- Request FIFO:
  - req_r_o = !full; full means occupancy==DEPTH.
  - Registered output: a packet pushed at edge N is first visible on fsb_data_o in cycle N+1.
  - No bypass when full. Simultaneous push and pop when not full leaves occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- Credit gating:
  - fsb_v_o = !empty && !(head[79] && outstanding==MAX_OUTSTANDING).
  - Head-of-line blocking is intentional; later packets never overtake the head.
  - A gated head keeps fsb_v_o low and does not assert-then-drop.
  - outstanding increments on an FSB request handshake with bit 79 = 1.
  - outstanding decrements on an fsb_resp handshake.
  - Same-cycle increment and decrement leaves it unchanged.
  - Decrement at 0: the counter stays 0 and resp_underflow_o sets. It clears only on reset.
- Response path:
  - 2-entry skid buffer; fsb_resp_r_o is registered, = (entries<2).
  - Latency from fsb_resp handshake to resp_v_o is 1 cycle.
  - Order is preserved, with full throughput when resp_r_i is held high.
- Counters:
  - tx_count_o increments on every FSB request handshake.
  - rx_count_o increments on every fsb_resp handshake.
  - Both wrap from 2^CNT_WIDTH-1 to 0.
- Mid-operation reset: all buffered packets are discarded, with no partial output. In-flight FSB responses arriving after reset are accepted normally. Each such response raises resp_underflow_o if outstanding==0.

Decomposition:
- Package fsb_adapter_pkg holds:
  - FSB_PKT_WIDTH=80 and FSB_RESP_FLAG_BIT=79.
  - fsb_pkt_t, a packed 80-bit typedef.
  - OUTSTANDING_WIDTH=8.
- Sub-module fsb_pkt_fifo: parameterised DEPTH, registered-output, valid/ready FIFO with occupancy output. It is instantiated once for the request path.
- The credit counter, skid buffer and status counters are inline.

Test Plan:
- Fill, then drain:
  - Stimulus: reset; push 16 packets with bit79=0 and fsb_r_i=0.
  - Response: req_r_o drops after the 16th push; occupancy_o=16.
  - Then assert fsb_r_i: packets emerge in order, one per cycle; tx_count_o=16; outstanding_o=0.
- Credit stall:
  - Stimulus: MAX_OUTSTANDING=8; push 10 packets with bit79=1, fsb_r_i=1, no responses.
  - Response: exactly 8 issue; fsb_v_o low; outstanding_o=8.
  - Then one response: the 9th issues the cycle after the decrement is registered.
- Simultaneous events:
  - Stimulus: at outstanding=3, issue a bit79=1 packet and accept a response in the same cycle.
  - Response: outstanding_o stays 3; tx_count_o and rx_count_o each +1.
- Underflow:
  - Stimulus: after reset, inject one response.
  - Response: resp_v_o=1 next cycle with matching data; resp_underflow_o=1 and sticky; outstanding_o=0.
- Response backpressure:
  - Stimulus: resp_r_i=0; send 3 responses.
  - Response: fsb_resp_r_o falls after 2 are accepted.
  - Then release resp_r_i: the data comes out in order, with no loss or duplication.
- Reset mid-stream:
  - Stimulus: with 5 entries queued and outstanding=2, assert reset_i for 1 cycle.
  - Response: occupancy_o=0; outstanding_o=0; counters=0; fsb_v_o=0; resp_v_o=0.
